// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types for the single-precision adder sequencer
package fp_pkg;
   localparam int FP_W = 32;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      ACK   = 3'd3,
      DRAIN = 3'd4
   } state_t;

   typedef struct packed {
      logic [FP_W-1:0] a;
      logic [FP_W-1:0] b;
   } pair_t;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count and same-cycle push/pop
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [W-1:0]           push_data,
   input  logic                   pop,
   output logic [W-1:0]           head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

   // Storage array: no reset needed, only written on an accepted push.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/fp_add_sequencer.sv
// rtl/fp_add_sequencer.sv - buffers operand pairs and issues them one at a time to the adder
module fp_add_sequencer
   import fp_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [FP_W-1:0]        in_a,
   input  logic [FP_W-1:0]        in_b,
   output logic                   add_load,
   output logic [FP_W-1:0]        add_number1,
   output logic [FP_W-1:0]        add_number2,
   output logic                   add_result_ack,
   input  logic [FP_W-1:0]        add_result,
   input  logic                   add_result_ready,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [FP_W-1:0]        out_result,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   busy,
   output logic                   err
);
   localparam int TW = $clog2(TIMEOUT + 1);

   state_t        state;
   logic [TW-1:0] timer;
   logic          pop;
   logic          push;
   logic          full;
   logic          empty;
   pair_t         head;
   pair_t         push_pair;
   logic          out_free;

   // Popping only happens on the IDLE->ISSUE step, so a full FIFO can still take a push then.
   assign pop       = (state == IDLE) && !empty;
   assign in_ready  = !full || pop;
   assign push      = in_valid && in_ready;
   assign push_pair = '{a: in_a, b: in_b};
   assign busy      = (state != IDLE) || (fifo_count != '0);
   // The output register can take a new sum if empty or being drained this cycle.
   assign out_free  = !out_valid || out_ready;

   sync_fifo #(
      .DEPTH (DEPTH),
      .W     (2 * FP_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_pair),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty),
      .count     (fifo_count)
   );

   // Issue FSM plus output register; a capture in WAIT overrides the default accept-clear.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= IDLE;
         add_load       <= 1'b0;
         add_number1    <= '0;
         add_number2    <= '0;
         add_result_ack <= 1'b0;
         out_valid      <= 1'b0;
         out_result     <= '0;
      end else begin
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (!empty) begin
                  add_number1 <= head.a;
                  add_number2 <= head.b;
                  add_load    <= 1'b1;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               if (add_result_ready) begin
                  add_load <= 1'b0;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (add_result_ready && out_free) begin
                  out_result     <= add_result;
                  out_valid      <= 1'b1;
                  add_result_ack <= 1'b1;
                  state          <= ACK;
               end
            end
            ACK: begin
               add_result_ack <= 1'b0;
               state          <= DRAIN;
            end
            DRAIN: begin
               if (!add_result_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Watchdog over ISSUE+WAIT; err is sticky until reset, the timer saturates.
   always_ff @(posedge clk) begin
      if (!reset) begin
         timer <= '0;
         err   <= 1'b0;
      end else if (state == ISSUE || state == WAIT) begin
         if (timer != TW'(TIMEOUT)) timer <= timer + 1'b1;
         if (timer == TW'(TIMEOUT - 1)) err <= 1'b1;
      end else begin
         timer <= '0;
      end
   end
endmodule

// File: tb/tb_fp_add_sequencer.sv
// tb/tb_fp_add_sequencer.sv - self-checking bench with behavioural adder and queue reference
module tb_fp_add_sequencer;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_a = '0;
   logic [31:0] in_b = '0;
   logic        add_load;
   logic [31:0] add_number1;
   logic [31:0] add_number2;
   logic        add_result_ack;
   logic [31:0] add_result;
   logic        add_result_ready;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;
   logic [2:0]  fifo_count;
   logic        busy;
   logic        err;

   int unsigned pass_cnt = 0;
   int unsigned total = 0;
   int unsigned fail_cnt = 0;

   // behavioural adder controls and monitors
   int          lat = 4;
   logic        stall = 1'b0;
   int          ad_st;
   int          ad_cnt;
   logic [31:0] op_sum;
   logic        load_q;
   int          proto_err = 0;

   logic [31:0] exp_q[$];
   logic [31:0] last_out;
   int          out_cnt = 0;
   int          ov_cycles = 0;
   int          ack_cnt = 0;
   int          load_cnt = 0;
   int          in_stall_cnt = 0;
   logic        prev_hold = 1'b0;
   logic [31:0] prev_res;
   logic        prev_load_n = 1'b0;

   fp_add_sequencer #(.DEPTH(4), .TIMEOUT(64)) dut (
      .clk              (clk),
      .reset            (reset),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_a             (in_a),
      .in_b             (in_b),
      .add_load         (add_load),
      .add_number1      (add_number1),
      .add_number2      (add_number2),
      .add_result_ack   (add_result_ack),
      .add_result       (add_result),
      .add_result_ready (add_result_ready),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_result       (out_result),
      .fifo_count       (fifo_count),
      .busy             (busy),
      .err              (err)
   );

   always #5 clk = ~clk;

   // Truncating add of two positive normal singles; the bench's stand-in adder.
   function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
      logic [31:0] a;
      logic [31:0] b;
      logic [7:0]  e;
      logic [7:0]  d;
      logic [24:0] ma;
      logic [24:0] mb;
      logic [24:0] s;
      if (x[30:23] < y[30:23]) begin a = y; b = x; end
      else begin a = x; b = y; end
      e  = a[30:23];
      d  = a[30:23] - b[30:23];
      ma = {2'b01, a[22:0]};
      mb = {2'b01, b[22:0]};
      mb = (d > 8'd24) ? 25'd0 : (mb >> d);
      s  = ma + mb;
      if (s[24]) begin s = s >> 1; e = e + 8'd1; end
      return {1'b0, e, s[22:0]};
   endfunction

   function automatic logic [31:0] rnd_fp();
      logic [31:0] v;
      v = {1'b0, 8'($urandom_range(110, 140)), 23'($urandom)};
      return v;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         fail_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Adder: latches operands on load, answers after lat cycles, holds until ack.
   always @(posedge clk) begin
      if (!reset) begin
         ad_st            <= 0;
         ad_cnt           <= 0;
         add_result_ready <= 1'b0;
         add_result       <= '0;
         load_q           <= 1'b0;
      end else begin
         load_q <= add_load;
         if (add_load && !load_q && ad_st != 0) proto_err <= proto_err + 1;
         case (ad_st)
            0: if (add_load) begin
               op_sum <= fadd(add_number1, add_number2);
               ad_cnt <= lat;
               ad_st  <= 1;
            end
            1: if (!stall) begin
               if (ad_cnt <= 1) begin
                  add_result_ready <= 1'b1;
                  add_result       <= op_sum;
                  ad_st            <= 2;
               end else begin
                  ad_cnt <= ad_cnt - 1;
               end
            end
            default: if (add_result_ack) begin
               add_result_ready <= 1'b0;
               ad_st            <= 0;
            end
         endcase
      end
   end

   // Reference scoreboard: accepted pairs queue their sums, outputs must match in order.
   always @(negedge clk) begin
      if (!reset) begin
         exp_q.delete();
         prev_hold <= 1'b0;
      end else begin
         if (in_valid && in_ready) exp_q.push_back(fadd(in_a, in_b));
         if (in_valid && !in_ready) in_stall_cnt++;
         if (out_valid) ov_cycles++;
         if (add_result_ack) ack_cnt++;
         if (add_load && !prev_load_n) load_cnt++;
         if (out_valid && prev_hold) check("out_stable", out_result, prev_res);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_out", 32'd1, 32'd0);
            else check("out_result", out_result, exp_q.pop_front());
            last_out = out_result;
            out_cnt++;
         end
         prev_hold <= out_valid && !out_ready;
         prev_res  <= out_result;
      end
      prev_load_n <= add_load;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] b);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) check("push_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (!busy && !out_valid && exp_q.size() == 0) begin ok = 1'b1; break; end
         tick();
      end
      check("idle_timeout", 32'(ok), 32'd1);
   endtask

   initial begin
      int base_out;
      int base_ack;
      int base_load;
      int base_ov;

      // 1. reset state, then 1.0 + 2.0
      repeat (2) tick();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_add_load", 32'(add_load), 32'd0);
      check("rst_ack", 32'(add_result_ack), 32'd0);
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_out_result", out_result, 32'd0);
      check("rst_number1", add_number1, 32'd0);
      reset = 1'b1;
      out_ready = 1'b1;
      lat = 4;
      tick();
      push(32'h3F800000, 32'h40000000);
      wait_idle();
      check("t1_out_cnt", 32'(out_cnt), 32'd1);
      check("t1_sum", last_out, 32'h40400000);
      check("t1_ov_cycles", 32'(ov_cycles), 32'd1);
      check("t1_loads", 32'(load_cnt), 32'd1);

      // 2. four back-to-back pairs
      base_out = out_cnt;
      in_stall_cnt = 0;
      lat = 2;
      push(32'h3FC00000, 32'h40200000);
      for (int i = 0; i < 3; i++) push(rnd_fp(), rnd_fp());
      check("t2_in_ready_held", 32'(in_stall_cnt), 32'd0);
      for (int i = 0; i < 20 && out_cnt == base_out; i++) tick();
      check("t2_first_sum", last_out, 32'h40800000);
      wait_idle();
      check("t2_out_cnt", 32'(out_cnt - base_out), 32'd4);
      check("t2_count", 32'(fifo_count), 32'd0);
      check("t2_busy", 32'(busy), 32'd0);

      // 3. consumer stalls with two queued
      out_ready = 1'b0;
      base_out = out_cnt;
      base_ack = ack_cnt;
      push(rnd_fp(), rnd_fp());
      push(rnd_fp(), rnd_fp());
      repeat (20) tick();
      check("t3_valid_held", 32'(out_valid), 32'd1);
      check("t3_single_ack", 32'(ack_cnt - base_ack), 32'd1);
      check("t3_head_value", out_result, exp_q[0]);
      out_ready = 1'b1;
      wait_idle();
      check("t3_out_cnt", 32'(out_cnt - base_out), 32'd2);
      check("t3_acks", 32'(ack_cnt - base_ack), 32'd2);

      // 4. fill the FIFO behind a stalled adder
      stall = 1'b1;
      base_out = out_cnt;
      push(rnd_fp(), rnd_fp());
      repeat (4) tick();
      for (int i = 0; i < 4; i++) push(rnd_fp(), rnd_fp());
      check("t4_full_count", 32'(fifo_count), 32'd4);
      check("t4_in_ready_low", 32'(in_ready), 32'd0);
      in_valid = 1'b1;
      in_a = rnd_fp();
      in_b = rnd_fp();
      repeat (5) tick();
      check("t4_ignored_count", 32'(fifo_count), 32'd4);
      check("t4_ignored_q", 32'(exp_q.size()), 32'd5);
      stall = 1'b0;
      push(in_a, in_b);
      check("t4_pushpop_count", 32'(fifo_count), 32'd4);
      wait_idle();
      check("t4_out_cnt", 32'(out_cnt - base_out), 32'd6);
      check("t4_err_clear", 32'(err), 32'd0);

      // 5. adder never answers
      stall = 1'b1;
      push(rnd_fp(), rnd_fp());
      repeat (40) tick();
      check("t5_err_early", 32'(err), 32'd0);
      repeat (40) tick();
      check("t5_err_set", 32'(err), 32'd1);
      repeat (20) tick();
      check("t5_err_sticky", 32'(err), 32'd1);
      reset = 1'b0;
      tick();
      check("t5_err_reset", 32'(err), 32'd0);
      stall = 1'b0;
      reset = 1'b1;
      tick();

      // 6. reset while waiting on a blocked output
      out_ready = 1'b0;
      lat = 2;
      push(rnd_fp(), rnd_fp());
      push(rnd_fp(), rnd_fp());
      repeat (20) tick();
      check("t6_pre_valid", 32'(out_valid), 32'd1);
      reset = 1'b0;
      tick();
      check("t6_out_valid", 32'(out_valid), 32'd0);
      check("t6_load", 32'(add_load), 32'd0);
      check("t6_ack", 32'(add_result_ack), 32'd0);
      check("t6_count", 32'(fifo_count), 32'd0);
      check("t6_out_result", out_result, 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      reset = 1'b1;
      out_ready = 1'b1;
      tick();
      base_out = out_cnt;
      push(32'h40000000, 32'h40000000);
      wait_idle();
      check("t6_out_cnt", 32'(out_cnt - base_out), 32'd1);
      check("t6_sum", last_out, 32'h40800000);
      check("protocol", 32'(proto_err), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
